// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared command type, mode constants and saturation limits for accumulator_array
package acc_pkg;

    localparam logic ACC_OVERWRITE  = 1'b0;
    localparam logic ACC_ACCUMULATE = 1'b1;

    // Commands carry a fixed-width address so one struct serves any DEPTH; banks range-check it.
    localparam int CMD_ADDR_W = 16;
    localparam int LIMIT_W    = 64;

    typedef struct packed {
        logic                  wr_en;
        logic                  acc_mode;
        logic [CMD_ADDR_W-1:0] wr_addr;
    } acc_cmd_t;

    localparam acc_cmd_t ACC_CMD_IDLE = '0;

    function automatic logic signed [LIMIT_W-1:0] acc_max(input int aw);
        return (64'sd1 <<< (aw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [LIMIT_W-1:0] acc_min(input int aw);
        return -(64'sd1 <<< (aw - 1));
    endfunction

endpackage

// File: rtl/accumulator_bank.sv
// rtl/accumulator_bank.sv - one column: entry storage, saturating read-modify-write, registered read, sticky overflow
module accumulator_bank
    import acc_pkg::*;
#(
    parameter int PSW        = 19,
    parameter int AW         = 24,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  acc_cmd_t              i_cmd,
    input  logic signed [PSW-1:0] i_psum,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic signed [AW-1:0]  o_rd_data,
    output logic                  o_ovf
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam logic signed [AW-1:0] SAT_MAX = AW'(acc_max(AW));
    localparam logic signed [AW-1:0] SAT_MIN = AW'(acc_min(AW));

    // Entries at or above DEPTH are never written, so reads of them always return zero.
    logic signed [AW-1:0]  r_mem [MEM_DEPTH];
    logic signed [AW-1:0]  r_rd_data;
    logic                  r_ovf;

    logic                  w_wr_hit;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic signed [AW-1:0]  w_old;
    logic signed [AW-1:0]  w_ext;
    logic signed [AW-1:0]  w_new;
    logic signed [AW:0]    w_sum;
    logic                  w_sat;

    assign w_wr_hit = i_cmd.wr_en && (i_cmd.wr_addr < CMD_ADDR_W'(DEPTH));
    assign w_wr_idx = i_cmd.wr_addr[ADDR_WIDTH-1:0];
    assign w_old    = r_mem[w_wr_idx];
    assign w_ext    = AW'(i_psum);
    assign w_sum    = (AW+1)'(w_old) + (AW+1)'(w_ext);

    always_comb begin
        w_sat = 1'b0;
        w_new = w_ext;
        if (i_cmd.acc_mode == ACC_ACCUMULATE) begin
            if (w_sum > (AW+1)'(SAT_MAX)) begin
                w_new = SAT_MAX;
                w_sat = 1'b1;
            end else if (w_sum < (AW+1)'(SAT_MIN)) begin
                w_new = SAT_MIN;
                w_sat = 1'b1;
            end else begin
                w_new = w_sum[AW-1:0];
            end
        end
    end

    // Read samples pre-edge contents, so a same-edge write or clear is not visible to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MEM_DEPTH; k++) r_mem[k] <= '0;
            r_rd_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
            if (i_clr) begin
                for (int k = 0; k < MEM_DEPTH; k++) r_mem[k] <= '0;
                r_ovf <= 1'b0;
            end else if (w_wr_hit) begin
                r_mem[w_wr_idx] <= w_new;
                if (w_sat) r_ovf <= 1'b1;
            end
        end
    end

    assign o_rd_data = r_rd_data;
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/accumulator_array.sv
// rtl/accumulator_array.sv - column-parallel partial-sum accumulator with skewed write wavefront
module accumulator_array
    import acc_pkg::*;
#(
    parameter int SYSTOLIC_SIZE     = 8,
    parameter int PARTIAL_SUM_WIDTH = 19,
    parameter int ACC_WIDTH         = 24,
    parameter int DEPTH             = 16,
    parameter int ADDR_WIDTH        = $clog2(DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_test_mode,
    input  logic                                   i_wr_en,
    input  logic                                   i_acc_mode,
    input  logic [ADDR_WIDTH-1:0]                  i_wr_addr,
    input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] i_psum_in_flat,
    input  logic                                   i_rd_en,
    input  logic [ADDR_WIDTH-1:0]                  i_rd_addr,
    output logic [ACC_WIDTH*SYSTOLIC_SIZE-1:0]     o_rd_data_flat,
    output logic                                   o_rd_valid,
    input  logic                                   i_clr,
    output logic                                   o_busy,
    output logic [SYSTOLIC_SIZE-1:0]               o_ovf_flat
);

    localparam int N   = SYSTOLIC_SIZE;
    localparam int PSW = PARTIAL_SUM_WIDTH;
    localparam int AW  = ACC_WIDTH;

    acc_cmd_t             w_live_cmd;
    acc_cmd_t             w_pipe_in;
    acc_cmd_t             r_pipe [1:N-1];
    acc_cmd_t             w_col_cmd [N];
    logic signed [AW-1:0] w_rd_data [N];
    logic                 r_rd_valid;
    logic                 w_busy;

    assign w_live_cmd = '{wr_en: i_wr_en, acc_mode: i_acc_mode, wr_addr: CMD_ADDR_W'(i_wr_addr)};
    // Test mode feeds bubbles so nothing issued there can surface later as a skewed write.
    assign w_pipe_in  = i_test_mode ? ACC_CMD_IDLE : w_live_cmd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < N; k++) r_pipe[k] <= ACC_CMD_IDLE;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_clr) begin
                for (int k = 1; k < N; k++) r_pipe[k] <= ACC_CMD_IDLE;
            end else begin
                r_pipe[1] <= w_pipe_in;
                for (int k = 2; k < N; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    always_comb begin
        w_busy = 1'b0;
        for (int k = 1; k < N; k++) w_busy = w_busy | r_pipe[k].wr_en;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_col
        if (gi == 0) begin : g_head
            assign w_col_cmd[gi] = w_live_cmd;
        end else begin : g_skew
            assign w_col_cmd[gi] = i_test_mode ? w_live_cmd : r_pipe[gi];
        end

        accumulator_bank #(
            .PSW        (PSW),
            .AW         (AW),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_clr     (i_clr),
            .i_cmd     (w_col_cmd[gi]),
            .i_psum    (i_psum_in_flat[gi*PSW +: PSW]),
            .i_rd_en   (i_rd_en),
            .i_rd_addr (i_rd_addr),
            .o_rd_data (w_rd_data[gi]),
            .o_ovf     (o_ovf_flat[gi])
        );

        assign o_rd_data_flat[gi*AW +: AW] = w_rd_data[gi];
    end

    assign o_rd_valid = r_rd_valid;
    assign o_busy     = w_busy;

endmodule

// File: tb/tb_accumulator_array.sv
// tb/tb_accumulator_array.sv - scoreboard bench for accumulator_array with directed vectors
module tb_accumulator_array;
    import acc_pkg::*;

    localparam int N          = 8;
    localparam int PSW        = 19;
    localparam int AW         = 24;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int FW         = N * AW;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  test_mode = 1'b0;
    logic                  wr_en     = 1'b0;
    logic                  acc_mode  = 1'b0;
    logic                  rd_en     = 1'b0;
    logic                  clr       = 1'b0;
    logic [ADDR_WIDTH-1:0] wr_addr   = '0;
    logic [ADDR_WIDTH-1:0] rd_addr   = '0;
    logic [PSW*N-1:0]      psum      = '0;
    logic [FW-1:0]         rd_data;
    logic                  rd_valid;
    logic                  busy;
    logic [N-1:0]          ovf;

    int            n_checks = 0;
    int            n_errors = 0;
    int            vin [N];
    int            ex [N];
    int            hist [N][N];
    logic [FW-1:0] exp_q [$];

    always #5 clk = ~clk;

    accumulator_array #(
        .SYSTOLIC_SIZE     (N),
        .PARTIAL_SUM_WIDTH (PSW),
        .ACC_WIDTH         (AW),
        .DEPTH             (DEPTH),
        .ADDR_WIDTH        (ADDR_WIDTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_test_mode    (test_mode),
        .i_wr_en        (wr_en),
        .i_acc_mode     (acc_mode),
        .i_wr_addr      (wr_addr),
        .i_psum_in_flat (psum),
        .i_rd_en        (rd_en),
        .i_rd_addr      (rd_addr),
        .o_rd_data_flat (rd_data),
        .o_rd_valid     (rd_valid),
        .i_clr          (clr),
        .o_busy         (busy),
        .o_ovf_flat     (ovf)
    );

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_ex();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < N; i++) f[i*AW +: AW] = AW'(ex[i]);
        return f;
    endfunction

    task automatic set_all(input int v);
        for (int i = 0; i < N; i++) vin[i] = v;
    endtask

    task automatic set_ramp(input int b);
        for (int i = 0; i < N; i++) vin[i] = b + i;
    endtask

    task automatic ex_all(input int v);
        for (int i = 0; i < N; i++) ex[i] = v;
    endtask

    task automatic ex_ramp(input int b, input int ncols);
        for (int i = 0; i < N; i++) ex[i] = (i < ncols) ? b + i : 0;
    endtask

    task automatic expect_read();
        exp_q.push_back(pack_ex());
    endtask

    // Column i sees the psum of the command issued i cycles ago (live one in test mode).
    task automatic step(input bit we, input bit acc, input int wa, input bit rd, input int ra);
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        for (int i = 0; i < N; i++) hist[0][i] = we ? vin[i] : 0;
        wr_en    = we;
        acc_mode = acc;
        wr_addr  = ADDR_WIDTH'(wa);
        rd_en    = rd;
        rd_addr  = ADDR_WIDTH'(ra);
        for (int i = 0; i < N; i++)
            psum[i*PSW +: PSW] = PSW'(test_mode ? hist[0][i] : hist[i][i]);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) chk("unexpected_rd_valid", FW'(rd_valid), '0);
            else                   chk("rd_data", rd_data, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++) hist[k][i] = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_rd_valid", FW'(rd_valid), '0);
        chk("reset_busy", FW'(busy), '0);
        chk("reset_ovf", FW'(ovf), '0);
        @(posedge clk);
        #1;

        set_ramp(1);
        step(1, ACC_OVERWRITE, 3, 0, 0);
        chk("ow_busy_start", FW'(busy), FW'(1));
        idle(1);
        ex_ramp(1, 2); expect_read(); step(0, 0, 0, 1, 3);
        idle(2);
        ex_ramp(1, 5); expect_read(); step(0, 0, 0, 1, 3);
        idle(1);
        chk("ow_busy_last", FW'(busy), FW'(1));
        idle(1);
        chk("ow_busy_fall", FW'(busy), '0);
        ex_ramp(1, 8); expect_read(); step(0, 0, 0, 1, 3);
        idle(1);
        chk("rd_hold_data", rd_data, pack_ex());
        chk("rd_valid_pulse", FW'(rd_valid), '0);

        set_all(100); step(1, ACC_OVERWRITE, 5, 0, 0);
        set_all(-30); step(1, ACC_ACCUMULATE, 5, 0, 0);
        set_all(5);   step(1, ACC_ACCUMULATE, 5, 0, 0);
        idle(7);
        ex_all(75); expect_read(); step(0, 0, 0, 1, 5);
        chk("acc_no_ovf", FW'(ovf), '0);

        set_all(-262136); step(1, ACC_OVERWRITE, 8, 0, 0);
        repeat (31) step(1, ACC_ACCUMULATE, 8, 0, 0);
        set_all(-248); step(1, ACC_ACCUMULATE, 8, 0, 0);
        set_all(-100); step(1, ACC_ACCUMULATE, 8, 0, 0);
        chk("neg_sat_ovf_col0", FW'(ovf), FW'(8'h01));
        idle(7);
        chk("neg_sat_ovf_all", FW'(ovf), FW'(8'hFF));
        ex_all(-8388608); expect_read(); step(0, 0, 0, 1, 8);

        test_mode = 1'b1;
        set_ramp(10); step(1, ACC_OVERWRITE, 9, 0, 0);
        chk("tm_busy", FW'(busy), '0);
        set_ramp(20); ex_ramp(10, 8); expect_read(); step(1, ACC_OVERWRITE, 9, 1, 9);
        ex_ramp(20, 8); expect_read(); step(0, 0, 0, 1, 9);
        test_mode = 1'b0;

        set_ramp(30); step(1, ACC_OVERWRITE, 10, 0, 0);
        idle(2);
        test_mode = 1'b1;
        idle(6);
        test_mode = 1'b0;
        ex_ramp(30, 3); expect_read(); step(0, 0, 0, 1, 10);

        set_ramp(90); clr = 1'b1;
        ex_ramp(1, 8); expect_read(); step(1, ACC_OVERWRITE, 3, 1, 3);
        chk("clr_ovf", FW'(ovf), '0);
        chk("clr_busy", FW'(busy), '0);
        idle(8);
        ex_all(0); expect_read(); step(0, 0, 0, 1, 3);
        expect_read(); step(0, 0, 0, 1, 8);

        set_all(262136); step(1, ACC_OVERWRITE, 7, 0, 0);
        repeat (31) step(1, ACC_ACCUMULATE, 7, 0, 0);
        set_all(248); step(1, ACC_ACCUMULATE, 7, 0, 0);
        set_all(100); step(1, ACC_ACCUMULATE, 7, 0, 0);
        chk("pos_sat_ovf_col0", FW'(ovf), FW'(8'h01));
        idle(7);
        chk("pos_sat_ovf_all", FW'(ovf), FW'(8'hFF));
        ex_all(8388607); expect_read(); step(0, 0, 0, 1, 7);

        set_ramp(40); step(1, ACC_OVERWRITE, 11, 0, 0);
        idle(1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd_data", rd_data, '0);
        chk("rst_mid_rd_valid", FW'(rd_valid), '0);
        chk("rst_mid_busy", FW'(busy), '0);
        chk("rst_mid_ovf", FW'(ovf), '0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        idle(8);
        ex_all(0); expect_read(); step(0, 0, 0, 1, 11);

        idle(2);
        chk("scoreboard_drained", FW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
